hex_display_ctrl: RTL and testbench

- Parametrised multi-digit hexadecimal display controller for the DE2-115 HEX bank and for external multiplexed displays.
- Accepts a packed nibble word through a valid/ready handshake and holds it in a display register.
- Drives per-digit active-low 7-segment glyphs with optional leading-zero blanking and per-digit blinking.
- In scan mode, also time-multiplexes a single segment bus with a one-hot active-low digit select.

---
 rtl/hex_disp_pkg.sv | 39 +++
 rtl/hex_display_ctrl_if.sv | 13 +
 rtl/disp_tick_gen.sv | 69 ++++++
 rtl/hex_display_ctrl.sv | 137 +++++++++++++
 tb/tb_hex_display_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/hex_disp_pkg.sv
// Shared types and the hex-to-7-segment glyph table for the hex display controller.
package hex_disp_pkg;

    // Every segment off (active-low encoding, bit order g..a).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef logic [6:0] glyph_t;

    // Load handshake state: idle (ready for a value) or holding a pending value.
    typedef enum logic {
        HS_IDLE    = 1'b0,
        HS_PENDING = 1'b1
    } hs_state_t;

    // Active-low glyph for one hex nibble, bit order g..a.
    function automatic glyph_t hex_glyph(input logic [3:0] nib);
        glyph_t g;
        case (nib)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h18;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Load channel of the hex display controller.
// Handshake: a value transfers on a clk edge where valid_i && ready_o are both 1;
// valid_i offered while ready_o is 0 is dropped, never queued.
interface hex_display_ctrl_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] value_i;
    logic                    valid_i;
    logic                    ready_o;

    modport master (output value_i, output valid_i, input ready_o);
    modport slave  (input value_i, input valid_i, output ready_o);
endinterface

// File: rtl/disp_tick_gen.sv
// Timebase for the display: prescaled tick, scan digit index, frame end and blink phase.
module disp_tick_gen #(
    parameter  int SCAN_DIV    = 50000,
    parameter  int BLINK_TICKS = 250,
    parameter  int NUM_DIGITS  = 8,
    localparam int PRE_W       = $clog2(SCAN_DIV),
    localparam int BLK_W       = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1,
    localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic             tick_o,
    output logic [IDX_W-1:0] index_o,
    output logic             frame_end_o,
    output logic             blink_phase_o
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0] presc_q, presc_d;
    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             blink_phase_q, blink_phase_d;
    logic             tick;

    // Next-state for prescaler, scan index and blink counter; all advance together on tick.
    always_comb begin
        presc_d       = presc_q;
        blink_cnt_d   = blink_cnt_q;
        index_d       = index_q;
        blink_phase_d = blink_phase_q;
        tick          = (presc_q == PRE_LAST);
        if (tick) begin
            presc_d = '0;
            index_d = (index_q == IDX_LAST) ? '0 : index_q + IDX_W'(1);
            if (blink_cnt_q == BLK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLK_W'(1);
            end
        end else begin
            presc_d = presc_q + PRE_W'(1);
        end
    end

    // Timebase registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q       <= '0;
            blink_cnt_q   <= '0;
            index_q       <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            blink_cnt_q   <= blink_cnt_d;
            index_q       <= index_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign tick_o        = tick;
    assign index_o       = index_q;
    assign frame_end_o   = tick && (index_q == IDX_LAST);
    assign blink_phase_o = blink_phase_q;

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit hex display controller: load handshake, leading-zero/blink blanking,
// and registered static or multiplexed 7-segment outputs.
module hex_display_ctrl
    import hex_disp_pkg::*;
#(
    parameter  int NUM_DIGITS  = 8,
    parameter  int SCAN_MODE   = 0,
    parameter  int SCAN_DIV    = 50000,
    parameter  int BLINK_TICKS = 250,
    localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    hex_display_ctrl_if.slave       bus,
    input  logic                    blank_lz_i,
    input  logic [NUM_DIGITS-1:0]   blink_mask_i,
    output logic [7*NUM_DIGITS-1:0] segments_o,
    output logic [6:0]              seg_mux_o,
    output logic [NUM_DIGITS-1:0]   digit_sel_o,
    output hs_state_t               dbg_state_o
);

    logic             tick;
    logic [IDX_W-1:0] index;
    logic             frame_end;
    logic             blink_phase;

    disp_tick_gen #(
        .SCAN_DIV    (SCAN_DIV),
        .BLINK_TICKS (BLINK_TICKS),
        .NUM_DIGITS  (NUM_DIGITS)
    ) u_tick_gen (
        .clk           (clk),
        .reset         (reset),
        .tick_o        (tick),
        .index_o       (index),
        .frame_end_o   (frame_end),
        .blink_phase_o (blink_phase)
    );

    hs_state_t               state_q, state_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [7*NUM_DIGITS-1:0] segments_q, segments_d;
    logic [6:0]              seg_mux_q, seg_mux_d;
    logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
    logic                    commit_ok;
    glyph_t                  glyphs [NUM_DIGITS];

    // Scan mode only commits at a frame boundary so a frame is never shown half old, half new.
    assign commit_ok = (SCAN_MODE == 0) ? 1'b1 : frame_end;

    // Handshake FSM: capture into pending when idle, copy pending to the display on commit.
    always_comb begin
        state_d    = state_q;
        pend_val_d = pend_val_q;
        disp_d     = disp_q;
        case (state_q)
            HS_IDLE: begin
                if (bus.valid_i) begin
                    pend_val_d = bus.value_i;
                    state_d    = HS_PENDING;
                end
            end
            HS_PENDING: begin
                if (commit_ok) begin
                    disp_d  = pend_val_q;
                    state_d = HS_IDLE;
                end
            end
            default: state_d = HS_IDLE;
        endcase
    end

    // Handshake and display registers; reset discards any pending value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= HS_IDLE;
            pend_val_q <= '0;
            disp_q     <= '0;
        end else begin
            state_q    <= state_d;
            pend_val_q <= pend_val_d;
            disp_q     <= disp_d;
        end
    end

    assign bus.ready_o = (state_q == HS_IDLE);
    assign dbg_state_o = state_q;

    // Per-digit glyph with blink and leading-zero blanking; scan from the top digit down.
    always_comb begin
        logic upper_zero;
        logic blank;
        upper_zero = 1'b1;
        blank      = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (disp_q[4*k +: 4] == 4'h0);
            blank      = (blink_mask_i[k] && blink_phase) ||
                         (blank_lz_i && upper_zero && (k != 0));
            glyphs[k]  = blank ? SEG_BLANK : hex_glyph(disp_q[4*k +: 4]);
        end
    end

    // Output stage next-state: all glyphs in static mode, one digit at a time in scan mode.
    always_comb begin
        segments_d  = '1;
        seg_mux_d   = SEG_BLANK;
        digit_sel_d = '1;
        if (SCAN_MODE == 0) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                segments_d[7*k +: 7] = glyphs[k];
            end
        end else begin
            seg_mux_d          = glyphs[index];
            digit_sel_d[index] = 1'b0;
        end
    end

    // Registered outputs; blank during and immediately after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            segments_q  <= '1;
            seg_mux_q   <= SEG_BLANK;
            digit_sel_q <= '1;
        end else begin
            segments_q  <= segments_d;
            seg_mux_q   <= seg_mux_d;
            digit_sel_q <= digit_sel_d;
        end
    end

    assign segments_o  = segments_q;
    assign seg_mux_o   = seg_mux_q;
    assign digit_sel_o = digit_sel_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl: one static-mode and one scan-mode instance share the stimulus.
// Expected outputs per cycle come from an arithmetic model of time since reset release.
module tb_hex_display_ctrl;
    import hex_disp_pkg::*;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BT = 2;
    localparam int W  = 40;  // {segments[27:0], seg_mux[6:0], digit_sel[3:0], ready}
    localparam logic [W-1:0] RESET_EXP = {28'hFFFFFFF, 7'h7F, 4'hF, 1'b1};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          blank_lz;
    logic [ND-1:0] mask;
    logic [15:0]   value;
    logic          valid;

    hex_display_ctrl_if #(.NUM_DIGITS(ND)) bus0 ();
    hex_display_ctrl_if #(.NUM_DIGITS(ND)) bus1 ();
    assign bus0.value_i = value;
    assign bus0.valid_i = valid;
    assign bus1.value_i = value;
    assign bus1.valid_i = valid;

    logic [27:0] seg0, seg1;
    logic [6:0]  mux0, mux1;
    logic [3:0]  sel0, sel1;
    hs_state_t   dbg0, dbg1;

    hex_display_ctrl #(.NUM_DIGITS(ND), .SCAN_MODE(0), .SCAN_DIV(SD), .BLINK_TICKS(BT)) dut0 (
        .clk(clk), .reset(rst), .bus(bus0.slave), .blank_lz_i(blank_lz), .blink_mask_i(mask),
        .segments_o(seg0), .seg_mux_o(mux0), .digit_sel_o(sel0), .dbg_state_o(dbg0));

    hex_display_ctrl #(.NUM_DIGITS(ND), .SCAN_MODE(1), .SCAN_DIV(SD), .BLINK_TICKS(BT)) dut1 (
        .clk(clk), .reset(rst), .bus(bus1.slave), .blank_lz_i(blank_lz), .blink_mask_i(mask),
        .segments_o(seg1), .seg_mux_o(mux1), .digit_sel_o(sel1), .dbg_state_o(dbg1));

    // ---------------- reference model ----------------
    logic [6:0] glyph_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // What the output register shows for a displayed word and the scan/blink position.
    function automatic logic [W-1:0] expect_out(input int mode, input logic [15:0] d,
                                                input int idx, input int ph,
                                                input logic lz, input logic [3:0] mk);
        logic [27:0] seg;
        logic [6:0]  mux;
        logic [3:0]  sel;
        logic [6:0]  g [4];
        logic        blank;
        seg = '1;
        mux = 7'h7F;
        sel = 4'hF;
        for (int k = 0; k < ND; k++) begin
            blank = (mk[k] && ph == 1) || (lz && k != 0 && (d >> (4 * k)) == 16'h0);
            g[k]  = blank ? 7'h7F : glyph_ref[d[4*k +: 4]];
        end
        if (mode == 0) begin
            for (int k = 0; k < ND; k++) seg[7*k +: 7] = g[k];
        end else begin
            mux      = g[idx];
            sel[idx] = 1'b0;
        end
        return {seg, mux, sel, 1'b0};
    endfunction

    int unsigned n_edges;         // clock edges since reset release
    logic [15:0] disp_m [2];
    logic [15:0] pval_m [2];
    logic        pend_m [2];
    logic [W-1:0] exp_q0 [$];
    logic [W-1:0] exp_q1 [$];

    // Model: per edge, push what each instance must show after that edge.
    always @(posedge clk) begin
        logic [W-1:0] e;
        int           idx;
        int           ph;
        if (rst) begin
            n_edges = 0;
            for (int m = 0; m < 2; m++) begin
                disp_m[m] = '0;
                pval_m[m] = '0;
                pend_m[m] = 1'b0;
            end
            exp_q0.push_back(RESET_EXP);
            exp_q1.push_back(RESET_EXP);
        end else begin
            idx = (n_edges / SD) % ND;
            ph  = ((n_edges / SD) / BT) % 2;
            for (int m = 0; m < 2; m++) begin
                e = expect_out(m, disp_m[m], idx, ph, blank_lz, mask);
                if (valid && !pend_m[m]) begin
                    pend_m[m] = 1'b1;
                    pval_m[m] = value;
                end else if (pend_m[m] && (m == 0 || ((n_edges + 1) % (SD * ND)) == 0)) begin
                    disp_m[m] = pval_m[m];
                    pend_m[m] = 1'b0;
                end
                e[0] = !pend_m[m];
                if (m == 0) exp_q0.push_back(e);
                else        exp_q1.push_back(e);
            end
            n_edges++;
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s t=%0t: got seg=%h mux=%h sel=%h rdy=%b, expected seg=%h mux=%h sel=%h rdy=%b",
                     name, $time, act[39:12], act[11:5], act[4:1], act[0],
                     exp[39:12], exp[11:5], exp[4:1], exp[0]);
        end
    endtask

    // Monitor: sample on the falling edge, pop one expectation per instance.
    always @(negedge clk) begin
        if (exp_q0.size() > 0) check("static", {seg0, mux0, sel0, bus0.ready_o}, exp_q0.pop_front());
        if (exp_q1.size() > 0) check("scan",   {seg1, mux1, sel1, bus1.ready_o}, exp_q1.pop_front());
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] v);
        int guard;
        guard = 0;
        while (!(bus0.ready_o && bus1.ready_o) && guard < 64) begin
            step(1);
            guard++;
        end
        if (guard >= 64) begin
            checks++;
            $display("FAIL ready_timeout: ready0=%b ready1=%b after %0d cycles, expected 1",
                     bus0.ready_o, bus1.ready_o, guard);
        end
        valid = 1'b1;
        value = v;
        step(1);
        valid = 1'b0;
    endtask

    task automatic align_frame(input int pos);
        int guard;
        guard = 0;
        while ((n_edges % (SD * ND)) != pos && guard < 64) begin
            step(1);
            guard++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst      = 1'b1;
        valid    = 1'b0;
        value    = '0;
        blank_lz = 1'b0;
        mask     = '0;
        step(3);
        rst = 1'b0;
        step(6);

        load(16'h3A0F);
        step(12);

        blank_lz = 1'b1;
        load(16'h0050);
        step(20);
        load(16'h0000);
        step(20);
        blank_lz = 1'b0;

        mask = 4'b0010;
        load(16'h1111);
        step(40);
        mask = '0;

        // Load landing at scan index 1 of a frame.
        align_frame(5);
        load(16'h1234);
        step(40);

        // Random traffic, including valid while busy.
        for (int i = 0; i < 300; i++) begin
            valid = ($urandom_range(0, 3) == 0);
            value = 16'($urandom);
            if ($urandom_range(0, 7) == 0) blank_lz = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) value[15:8] = 8'h00;
            step(1);
        end
        valid = 1'b0;
        mask  = '0;
        step(20);

        // Reset while the scan instance holds a pending value.
        align_frame(2);
        load(16'hBEEF);
        step(2);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_reset_static", {seg0, mux0, sel0, bus0.ready_o}, RESET_EXP);
        check("async_reset_scan",   {seg1, mux1, sel1, bus1.ready_o}, RESET_EXP);
        step(2);
        rst = 1'b0;
        step(40);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
